muldiv_unit: RTL

- Iterative 32-bit multiply/divide execution unit, directly downstream of the register bank.
- Consumes the two read-port operands (data1/data2) plus the destination register address.
- Produces a write-back (enable, address, data) that drives the bank's write port, and exposes HI/LO result registers.
- Multi-cycle: asserts busy so control stalls the PC while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_signfix.sv | 13 +
 rtl/muldiv_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and the divide-by-zero quotient pattern.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULU = 2'b01,
    OP_DIV  = 2'b10,
    OP_DIVU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  // Sliced down to the datapath width at the point of use.
  localparam logic [63:0] DIV0_QUOT = '1;

  function automatic logic is_div_op(input op_e o);
    return o[1];
  endfunction

  function automatic logic is_signed_op(input op_e o);
    return ~o[0];
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate; with i_neg = sign bit it yields |i_val|,
// with i_neg = result sign it restores a signed result from its magnitude.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? ((~i_val) + W'(1)) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit feeding the register bank write port.
// Magnitudes are formed one cycle after capture, then shift-add / restoring divide.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_W-1:0]     op_a,
  input  logic [DATA_W-1:0]     op_b,
  input  logic [REG_ADDR_W-1:0] dest,
  output logic                  busy,
  output logic                  done,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W-1:0]     hi,
  output logic [DATA_W-1:0]     lo
);

  localparam int CNT_W = $clog2(DATA_W);

  state_e                  r_state;
  state_e                  w_next;
  op_e                     r_op;
  logic [REG_ADDR_W-1:0]   r_dest;
  logic                    r_sign_a;
  logic                    r_sign_b;
  logic                    r_prep;
  logic [DATA_W-1:0]       r_raw_a;
  logic [DATA_W-1:0]       r_raw_b;
  logic [DATA_W-1:0]       r_x;
  logic [DATA_W-1:0]       r_y;
  logic [2*DATA_W-1:0]     r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic [DATA_W-1:0]       r_hi;
  logic [DATA_W-1:0]       r_lo;
  logic [DATA_W-1:0]       r_wr_data;

  logic [DATA_W-1:0]       w_abs_a;
  logic [DATA_W-1:0]       w_abs_b;
  logic [2*DATA_W-1:0]     w_prod;
  logic [DATA_W-1:0]       w_quot;
  logic [DATA_W-1:0]       w_rem;
  logic [DATA_W:0]         w_add;
  logic [DATA_W:0]         w_shift;
  logic [DATA_W-1:0]       w_diff;
  logic                    w_ge;
  logic [2*DATA_W-1:0]     w_iter;
  logic                    w_div0;

  muldiv_signfix #(.W(DATA_W)) u_abs_a (
    .i_val(r_raw_a), .i_neg(r_sign_a), .o_val(w_abs_a)
  );

  muldiv_signfix #(.W(DATA_W)) u_abs_b (
    .i_val(r_raw_b), .i_neg(r_sign_b), .o_val(w_abs_b)
  );

  muldiv_signfix #(.W(2*DATA_W)) u_fix_prod (
    .i_val(r_acc), .i_neg(r_sign_a ^ r_sign_b), .o_val(w_prod)
  );

  muldiv_signfix #(.W(DATA_W)) u_fix_quot (
    .i_val(r_acc[DATA_W-1:0]), .i_neg(r_sign_a ^ r_sign_b), .o_val(w_quot)
  );

  muldiv_signfix #(.W(DATA_W)) u_fix_rem (
    .i_val(r_acc[2*DATA_W-1:DATA_W]), .i_neg(r_sign_a), .o_val(w_rem)
  );

  // Divide holds {remainder, quotient} in r_acc; multiply holds the product
  // with the multiplier consumed LSB first out of r_y.
  always_comb begin
    w_add   = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + {1'b0, r_x};
    w_shift = {r_acc[2*DATA_W-1:DATA_W], r_acc[DATA_W-1]};
    w_diff  = w_shift[DATA_W-1:0] - r_y;
    w_ge    = (w_shift >= {1'b0, r_y});
    w_div0  = (r_y == '0);
    if (is_div_op(r_op)) begin
      w_iter = w_ge ? {w_diff, r_acc[DATA_W-2:0], 1'b1}
                    : {w_shift[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0};
    end else begin
      w_iter = r_y[0] ? {w_add, r_acc[DATA_W-1:1]}
                      : {1'b0, r_acc[2*DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_BUSY;
      S_BUSY:  if (!r_prep && (r_cnt == CNT_W'(DATA_W-1))) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op      <= OP_MUL;
      r_dest    <= '0;
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
      r_prep    <= 1'b0;
      r_raw_a   <= '0;
      r_raw_b   <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_wr_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op     <= op_e'(op);
            r_dest   <= dest;
            r_raw_a  <= op_a;
            r_raw_b  <= op_b;
            r_sign_a <= is_signed_op(op_e'(op)) & op_a[DATA_W-1];
            r_sign_b <= is_signed_op(op_e'(op)) & op_b[DATA_W-1];
            r_acc    <= '0;
            r_cnt    <= '0;
            r_prep   <= 1'b1;
          end
        end
        S_BUSY: begin
          // First busy cycle only loads magnitudes, keeping the abs adders
          // off the register-bank read path.
          if (r_prep) begin
            r_prep <= 1'b0;
            r_x    <= w_abs_a;
            r_y    <= w_abs_b;
            r_acc  <= is_div_op(r_op) ? {{DATA_W{1'b0}}, w_abs_a} : '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_acc <= w_iter;
            if (!is_div_op(r_op)) r_y <= r_y >> 1;
          end
        end
        S_FIX: begin
          if (is_div_op(r_op)) begin
            r_lo      <= w_div0 ? DIV0_QUOT[DATA_W-1:0] : w_quot;
            r_wr_data <= w_div0 ? DIV0_QUOT[DATA_W-1:0] : w_quot;
            r_hi      <= w_div0 ? r_raw_a : w_rem;
          end else begin
            r_lo      <= w_prod[DATA_W-1:0];
            r_wr_data <= w_prod[DATA_W-1:0];
            r_hi      <= w_prod[2*DATA_W-1:DATA_W];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign wr_en   = (r_state == S_DONE);
  assign wr_addr = r_dest;
  assign wr_data = r_wr_data;
  assign hi      = r_hi;
  assign lo      = r_lo;

endmodule
